// File: rtl/exe_arb_pkg.sv
// Shared definitions for the EXE-stage arbiter.
// Holds the default widths, the requester id type and the ALU operation
// codes that EXE and decode also use.
package exe_arb_pkg;

  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_OP_W   = 3;
  localparam int unsigned ARB_CNT_W  = 16;

  // Requester id: 0 = main pipeline, 1 = auxiliary unit
  typedef logic req_id_t;

  localparam req_id_t REQ_MAIN = 1'b0;
  localparam req_id_t REQ_AUX  = 1'b1;

  // ALU operation codes (the arbiter passes these through unchanged)
  localparam logic [ARB_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ARB_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ARB_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ARB_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ARB_OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ARB_OP_W-1:0] ALU_SLL = 3'd5;
  localparam logic [ARB_OP_W-1:0] ALU_SRL = 3'd6;
  localparam logic [ARB_OP_W-1:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   req_valid  - request valid per requester
//   last_grant - requester granted most recently (register lives in parent)
//   enable     - grant allowed this cycle (response slot free, out of reset)
//   grant_c    - one-hot grant or zero
module rr_arb2
  import exe_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  req_id_t    last_grant,
  input  logic       enable,
  output logic [1:0] grant_c
);

  // On a tie, the requester that did not win last time gets the grant
  always_comb begin
    grant_c = 2'b00;
    if (enable) begin
      unique case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = (last_grant == REQ_AUX) ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/exe_alu_arbiter.sv
// Shares the combinational EXE stage between the main pipeline (requester 0)
// and an auxiliary unit (requester 1). Round-robin grant, EXE inputs driven
// from the winner, ALU result captured into a one-entry response register
// with valid/ready handshake, saturating per-requester grant counters.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req_valid / req_ready           - request handshake per requester
//   req{0,1}_op/_opb_sel/_data1/_data2/_imm - request payloads
//   exe_alu_signal/exe_opb_select/exe_data1/exe_data2/exe_imm - to EXE
//   exe_result                      - from EXE (combinational)
//   rsp_valid/rsp_ready/rsp_id/rsp_data - response handshake and payload
//   grant_cnt0 / grant_cnt1         - accepted requests, saturating
module exe_alu_arbiter
  import exe_arb_pkg::*;
#(
  parameter int unsigned DATA_W = exe_arb_pkg::ARB_DATA_W,
  parameter int unsigned OP_W   = exe_arb_pkg::ARB_OP_W,
  parameter int unsigned CNT_W  = exe_arb_pkg::ARB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,

  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_opb_sel,
  input  logic [DATA_W-1:0] req0_data1,
  input  logic [DATA_W-1:0] req0_data2,
  input  logic [DATA_W-1:0] req0_imm,

  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_opb_sel,
  input  logic [DATA_W-1:0] req1_data1,
  input  logic [DATA_W-1:0] req1_data2,
  input  logic [DATA_W-1:0] req1_imm,

  output logic [OP_W-1:0]   exe_alu_signal,
  output logic              exe_opb_select,
  output logic [DATA_W-1:0] exe_data1,
  output logic [DATA_W-1:0] exe_data2,
  output logic [DATA_W-1:0] exe_imm,
  input  logic [DATA_W-1:0] exe_result,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,

  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  req_id_t    last_grant;
  logic [1:0] grant_c;
  logic       slot_free_c;
  logic       accept_c;
  req_id_t    accept_id_c;

  // Slot can take a new result if empty or being drained this cycle
  assign slot_free_c = !rsp_valid || rsp_ready;

  // rst_n in the enable keeps req_ready low while reset is held
  rr_arb2 u_rr_arb2 (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .enable     (slot_free_c && rst_n),
    .grant_c    (grant_c)
  );

  // A grant is only ever issued to a valid requester, so grant == accept
  assign req_ready   = grant_c;
  assign accept_c    = |grant_c;
  assign accept_id_c = grant_c[1];

  // EXE input mux; all-zero when idle so EXE inputs do not toggle
  always_comb begin
    exe_alu_signal = '0;
    exe_opb_select = 1'b0;
    exe_data1      = '0;
    exe_data2      = '0;
    exe_imm        = '0;
    if (grant_c[0]) begin
      exe_alu_signal = req0_op;
      exe_opb_select = req0_opb_sel;
      exe_data1      = req0_data1;
      exe_data2      = req0_data2;
      exe_imm        = req0_imm;
    end else if (grant_c[1]) begin
      exe_alu_signal = req1_op;
      exe_opb_select = req1_opb_sel;
      exe_data1      = req1_data1;
      exe_data2      = req1_data2;
      exe_imm        = req1_imm;
    end
  end

  // Response slot and round-robin pointer; refill wins over drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= REQ_AUX;
    end else if (accept_c) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= exe_result;
      rsp_id     <= accept_id_c;
      last_grant <= accept_id_c;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Saturating grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant_c[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant_c[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_alu_arbiter.sv
// Directed bench for exe_alu_arbiter with a bench-side EXE model and a
// response scoreboard. A second instance with 4-bit counters shares the
// stimulus to exercise counter saturation.
module tb_exe_alu_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic          req0_opb_sel, req1_opb_sel;
  logic [DW-1:0] req0_data1, req0_data2, req0_imm;
  logic [DW-1:0] req1_data1, req1_data2, req1_imm;
  logic [OW-1:0] exe_alu_signal;
  logic          exe_opb_select;
  logic [DW-1:0] exe_data1, exe_data2, exe_imm, exe_result;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_data;
  logic [15:0]   grant_cnt0, grant_cnt1;

  // Small-counter instance outputs
  logic [1:0]    s_req_ready;
  logic [OW-1:0] s_alu_signal;
  logic          s_opb_select;
  logic [DW-1:0] s_data1, s_data2, s_imm, s_result;
  logic          s_rsp_valid, s_rsp_id;
  logic [DW-1:0] s_rsp_data;
  logic [3:0]    s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb_q[$];   // {rsp_id, rsp_data}

  always #5 clk = ~clk;

  // Reference EXE ALU
  function automatic logic [DW-1:0] alu(input logic [OW-1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return DW'($signed(a) < $signed(b));
    endcase
  endfunction

  assign exe_result = alu(exe_alu_signal, exe_data1, exe_opb_select ? exe_imm : exe_data2);
  assign s_result   = alu(s_alu_signal, s_data1, s_opb_select ? s_imm : s_data2);

  exe_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_opb_sel(req0_opb_sel), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_imm(req0_imm),
    .req1_op(req1_op), .req1_opb_sel(req1_opb_sel), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_imm(req1_imm),
    .exe_alu_signal(exe_alu_signal), .exe_opb_select(exe_opb_select),
    .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_imm(exe_imm),
    .exe_result(exe_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  exe_alu_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(s_req_ready),
    .req0_op(req0_op), .req0_opb_sel(req0_opb_sel), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_imm(req0_imm),
    .req1_op(req1_op), .req1_opb_sel(req1_opb_sel), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_imm(req1_imm),
    .exe_alu_signal(s_alu_signal), .exe_opb_select(s_opb_select),
    .exe_data1(s_data1), .exe_data2(s_data2), .exe_imm(s_imm),
    .exe_result(s_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check grant at negedge, retire/push scoreboard,
  // return at posedge+1.
  task automatic step(input logic [1:0] v, input logic rr,
                      input logic [1:0] exp_ready, input string tag);
    logic [DW:0] exp_rsp;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".unexpected_rsp"}, 64'(rsp_valid), 64'(1'b0));
      end else begin
        exp_rsp = sb_q.pop_front();
        chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(exp_rsp[DW]));
        chk({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_rsp[DW-1:0]));
      end
    end
    if (exp_ready == 2'b01)
      sb_q.push_back({1'b0, alu(req0_op, req0_data1, req0_opb_sel ? req0_imm : req0_data2)});
    else if (exp_ready == 2'b10)
      sb_q.push_back({1'b1, alu(req1_op, req1_data1, req1_opb_sel ? req1_imm : req1_data2)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_op = '0; req0_opb_sel = 1'b0; req0_data1 = '0; req0_data2 = '0; req0_imm = '0;
    req1_op = '0; req1_opb_sel = 1'b0; req1_data1 = '0; req1_data2 = '0; req1_imm = '0;

    // Reset state, req_ready low while reset held even with requests
    #3 req_valid = 2'b11;
    #1;
    chk("rst.ready", 64'(req_ready), 64'(2'b00));
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("rst.rsp_data", 64'(rsp_data), 64'(0));
    chk("rst.rsp_id", 64'(rsp_id), 64'(1'b0));
    chk("rst.cnt0", 64'(grant_cnt0), 64'(0));
    chk("rst.cnt1", 64'(grant_cnt1), 64'(0));
    req_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Req0 alone: ADD 0 + imm 8
    req0_op = 3'd0; req0_opb_sel = 1'b1; req0_data1 = 32'd0; req0_imm = 32'd8;
    step(2'b01, 1'b1, 2'b01, "t1");
    chk("t1.rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("t1.rsp_id", 64'(rsp_id), 64'(1'b0));
    chk("t1.rsp_data", 64'(rsp_data), 64'(32'd8));
    chk("t1.cnt0", 64'(grant_cnt0), 64'(1));
    step(2'b00, 1'b1, 2'b00, "t1.drain");
    chk("t1.empty", 64'(rsp_valid), 64'(1'b0));

    // Both valid, last grant was 0 -> 1,0,1,0, one response per cycle
    req0_op = 3'd0; req0_opb_sel = 1'b0; req0_data1 = 32'd5;  req0_data2 = 32'd3;
    req1_op = 3'd1; req1_opb_sel = 1'b0; req1_data1 = 32'd20; req1_data2 = 32'd7;
    step(2'b11, 1'b1, 2'b10, "t2.a");
    step(2'b11, 1'b1, 2'b01, "t2.b");
    chk("t2.full", 64'(rsp_valid), 64'(1'b1));
    step(2'b11, 1'b1, 2'b10, "t2.c");
    step(2'b11, 1'b1, 2'b01, "t2.d");
    step(2'b00, 1'b1, 2'b00, "t2.drain");

    // Backpressure: FULL with req0 result, req1 waits 3 cycles
    req0_op = 3'd3; req0_opb_sel = 1'b1; req0_data1 = 32'hF0; req0_imm = 32'h0F;
    step(2'b01, 1'b1, 2'b01, "t3.fill");
    req1_op = 3'd4; req1_opb_sel = 1'b0; req1_data1 = 32'd10; req1_data2 = 32'd4;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0, 2'b00, "t3.hold");
      chk("t3.hold_data", 64'(rsp_data), 64'(32'hFF));
      chk("t3.hold_valid", 64'(rsp_valid), 64'(1'b1));
    end
    step(2'b10, 1'b1, 2'b10, "t3.release");
    chk("t3.rsp_id", 64'(rsp_id), 64'(1'b1));
    chk("t3.rsp_data", 64'(rsp_data), 64'(32'd14));

    // Only req1 valid after a req1 grant -> granted again
    step(2'b10, 1'b1, 2'b10, "t4.again");
    step(2'b00, 1'b1, 2'b00, "t4.drain");
    chk("t4.cnt0", 64'(grant_cnt0), 64'(4));
    chk("t4.cnt1", 64'(grant_cnt1), 64'(4));

    // Reset mid-operation while FULL
    step(2'b01, 1'b0, 2'b01, "t5.fill");
    chk("t5.full", 64'(rsp_valid), 64'(1'b1));
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("t5.rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("t5.cnt0", 64'(grant_cnt0), 64'(0));
    chk("t5.cnt1", 64'(grant_cnt1), 64'(0));
    chk("t5.ready", 64'(req_ready), 64'(2'b00));
    sb_q.delete();
    req_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5.no_rsp", 64'(rsp_valid), 64'(1'b0));
    req0_op = 3'd2; req0_opb_sel = 1'b0; req0_data1 = 32'hFF00; req0_data2 = 32'h0FF0;
    req1_op = 3'd7; req1_opb_sel = 1'b1; req1_data1 = 32'hFFFF_FFFE; req1_imm = 32'd1;
    step(2'b11, 1'b1, 2'b01, "t5.a");
    step(2'b11, 1'b1, 2'b10, "t5.b");
    step(2'b11, 1'b1, 2'b01, "t5.c");
    step(2'b11, 1'b1, 2'b10, "t5.d");
    step(2'b00, 1'b1, 2'b00, "t5.drain");

    // 20 req0 grants: 4-bit counter saturates at 15, grants continue
    req0_op = 3'd5; req0_opb_sel = 1'b1; req0_imm = 32'd2;
    for (int i = 0; i < 20; i++) begin
      req0_data1 = DW'(i + 1);
      step(2'b01, 1'b1, 2'b01, "t6.grant");
      if (i == 12) chk("t6.sat_reach", 64'(s_cnt0), 64'(15));
    end
    step(2'b00, 1'b1, 2'b00, "t6.drain");
    chk("t6.sat_hold", 64'(s_cnt0), 64'(15));
    chk("t6.cnt0_wide", 64'(grant_cnt0), 64'(22));
    chk("t6.sat_cnt1", 64'(s_cnt1), 64'(2));
    chk("end.sb_empty", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_alu_arbiter.md
# exe_alu_arbiter

Shares the single combinational EXE stage (operands, immediate, 3-bit ALU operation, operand-B select) between two requesters: the main pipeline (requester 0) and an auxiliary unit (requester 1). It arbitrates round-robin, drives the EXE inputs for the granted request, and captures the ALU result into a one-entry response register with a valid/ready handshake. Per-requester saturating grant counters provide performance visibility.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 3, ALU operation code width
- CNT_W, 16, grant counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid[1:0]  in  2  request valid per requester
- req_ready[1:0]  out  2  request accepted this cycle (one-hot or zero)
- req0_op / req1_op  in  OP_W  ALU operation
- req0_opb_sel / req1_opb_sel  in  1  1 = operand B from immediate, 0 = from data2
- req0_data1 / req1_data1  in  DATA_W  operand A
- req0_data2 / req1_data2  in  DATA_W  register operand B
- req0_imm / req1_imm  in  DATA_W  extended immediate
- exe_alu_signal  out  OP_W  to EXE ALUSignal
- exe_opb_select  out  1  to EXE OpbSelect
- exe_data1 / exe_data2 / exe_imm  out  DATA_W  to EXE Data1 / Data2 / ImmExtend
- exe_result  in  DATA_W  from EXE ALUResult (combinational)
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DATA_W  captured ALU result
- grant_cnt0 / grant_cnt1  out  CNT_W  accepted requests per requester, saturating

## Operation
- Response slot states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- slot_free = !rsp_valid || rsp_ready.
- Grant only when slot_free. One valid requester: grant it. Both valid: grant the one not equal to last_grant. None: no grant.
- req_ready[i] = grant to i (combinational from req_valid, last_grant, rsp_valid, rsp_ready). Accept = req_valid[i] && req_ready[i].
- On accept: EXE inputs driven from requester i same cycle; at the edge rsp_data <= exe_result, rsp_id <= i, rsp_valid <= 1, last_grant <= i, grant_cnt[i] += 1 unless at all-ones.
- No accept and rsp_ready && rsp_valid: rsp_valid <= 0; rsp_data/rsp_id hold.
- Accept and drain in the same cycle: slot refilled, rsp_valid stays 1 (back-to-back).
- No grant: EXE inputs driven to all zero (deterministic, no toggling).
- Requester must hold its payload stable while valid and not ready; arbiter does not buffer requests.
- ALU op codes pass through unchanged; arbiter never interprets them.

## Timing
- Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, grant_cnt0/1 0, last_grant 1 (requester 0 wins first tie); req_ready 0 while rst_n low.
- Latency: accept in cycle N, rsp_valid/rsp_data visible in cycle N+1.
- Throughput: one result per cycle while rsp_ready held high.
- Backpressure: FULL and rsp_ready=0 gives req_ready=00; response held stable.
- Reset asserted mid-operation: held response discarded, counters cleared, last_grant back to 1, no response emitted after release until a new accept.
- Counter saturation: at 2^CNT_W-1 the counter holds; grants continue.

## Structure
- Package exe_arb_pkg: DATA_W/OP_W defaults, req_id_t (1-bit requester id), ALU op code localparams shared with EXE and decode.
- Sub-module rr_arb2: 2-way round-robin grant from req_valid, last_grant, enable (slot_free); purely combinational, last_grant register in parent.
- EXE instantiated outside; the arbiter only drives/receives its ports.

## Test plan
- Req0 alone: op 000, opb_sel 1, data1 0, imm 8 -> req_ready=01, next cycle rsp_valid 1, rsp_id 0, rsp_data equals EXE model (8), grant_cnt0 1.
- Both valid continuously after reset, rsp_ready 1 -> grants alternate 0,1,0,1; rsp_id follows one cycle later, one response per cycle.
- Response held with rsp_ready 0 for 3 cycles while req1 valid (op 100, data1 10, data2 4, opb_sel 0) -> req_ready 00, rsp_data stable; on rsp_ready 1, req1 granted same cycle and its result appears next cycle.
- Only req1 valid after a req1 grant -> req1 granted again (no idle slot forced).
- rst_n pulsed low while FULL -> rsp_valid 0, counters 0 asynchronously; after release, first tie goes to req0.
- CNT_W=4, 20 req0 grants -> grant_cnt0 saturates at 15, grants keep completing.
